// File: rtl/dj8v_ext_bus_ctrl.sv
// dj8v memory-bus controller: serialises one 16-bit-address / 8-bit-data access
// over the shared uio port as ADDR_HI, ADDR_LO, DATA (WAIT_CYCLES+1 cycles), DONE.
module dj8v_ext_bus_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output logic        ready,
    output logic        busy,
    output logic [7:0]  rdata,
    input  logic [7:0]  uio_in,
    output logic [7:0]  uio_out,
    output logic [7:0]  uio_oe,
    output logic        ale_hi,
    output logic        ale_lo,
    output logic        rd_n,
    output logic        wr_n
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ADDR_HI = 3'd1;
    localparam logic [2:0] S_ADDR_LO = 3'd2;
    localparam logic [2:0] S_DATA    = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]  state, state_nxt;
    logic [3:0]  wait_cnt, wait_cnt_nxt;
    logic        cap_we, cap_we_nxt;
    logic [15:0] cap_addr, cap_addr_nxt;
    logic [7:0]  cap_wdata, cap_wdata_nxt;
    logic [7:0]  uio_out_nxt, uio_oe_nxt;

    always_comb begin
        state_nxt     = state;
        wait_cnt_nxt  = wait_cnt;
        cap_we_nxt    = cap_we;
        cap_addr_nxt  = cap_addr;
        cap_wdata_nxt = cap_wdata;
        case (state)
            S_IDLE: begin
                if (req) begin
                    state_nxt     = S_ADDR_HI;
                    cap_we_nxt    = we;
                    cap_addr_nxt  = addr;
                    cap_wdata_nxt = wdata;
                end
            end
            S_ADDR_HI: state_nxt = S_ADDR_LO;
            S_ADDR_LO: begin
                state_nxt    = S_DATA;
                wait_cnt_nxt = 4'(WAIT_CYCLES);
            end
            S_DATA: begin
                if (wait_cnt == 4'd0) state_nxt = S_DONE;
                else                  wait_cnt_nxt = wait_cnt - 4'd1;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so each phase is visible in its own cycle.
    always_comb begin
        uio_out_nxt = '0;
        uio_oe_nxt  = '0;
        case (state_nxt)
            S_ADDR_HI: begin
                uio_out_nxt = cap_addr_nxt[15:8];
                uio_oe_nxt  = '1;
            end
            S_ADDR_LO: begin
                uio_out_nxt = cap_addr_nxt[7:0];
                uio_oe_nxt  = '1;
            end
            S_DATA, S_DONE: begin
                if (cap_we_nxt) begin
                    uio_out_nxt = cap_wdata_nxt;
                    uio_oe_nxt  = '1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            ready     <= 1'b0;
            busy      <= 1'b0;
            rdata     <= '0;
            uio_out   <= '0;
            uio_oe    <= '0;
            ale_hi    <= 1'b0;
            ale_lo    <= 1'b0;
            rd_n      <= 1'b1;
            wr_n      <= 1'b1;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            cap_we    <= cap_we_nxt;
            cap_addr  <= cap_addr_nxt;
            cap_wdata <= cap_wdata_nxt;
            ready     <= (state_nxt == S_DONE);
            busy      <= (state_nxt != S_IDLE);
            uio_out   <= uio_out_nxt;
            uio_oe    <= uio_oe_nxt;
            ale_hi    <= (state_nxt == S_ADDR_HI);
            ale_lo    <= (state_nxt == S_ADDR_LO);
            rd_n      <= !((state_nxt == S_DATA) && !cap_we_nxt);
            wr_n      <= !((state_nxt == S_DATA) && cap_we_nxt);
            if ((state == S_DATA) && (state_nxt == S_DONE) && !cap_we)
                rdata <= uio_in;
        end
    end

endmodule

// File: tb/tb_dj8v_ext_bus_ctrl.sv
// Bench for dj8v_ext_bus_ctrl: WAIT_CYCLES=1 and WAIT_CYCLES=0 instances share stimulus
// and are compared every cycle against an offset-based model, plus vector table and corner sequences.
module tb_dj8v_ext_bus_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req, we;
    logic [15:0] addr;
    logic [7:0]  wdata, uio_in;

    logic        ready_o [2];
    logic        busy_o  [2];
    logic        ale_hi_o[2];
    logic        ale_lo_o[2];
    logic        rd_n_o  [2];
    logic        wr_n_o  [2];
    logic [7:0]  rdata_o [2];
    logic [7:0]  uio_out_o[2];
    logic [7:0]  uio_oe_o[2];

    dj8v_ext_bus_ctrl #(.WAIT_CYCLES(1)) dut0 (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ready(ready_o[0]), .busy(busy_o[0]), .rdata(rdata_o[0]), .uio_in(uio_in),
        .uio_out(uio_out_o[0]), .uio_oe(uio_oe_o[0]), .ale_hi(ale_hi_o[0]),
        .ale_lo(ale_lo_o[0]), .rd_n(rd_n_o[0]), .wr_n(wr_n_o[0])
    );

    dj8v_ext_bus_ctrl #(.WAIT_CYCLES(0)) dut1 (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ready(ready_o[1]), .busy(busy_o[1]), .rdata(rdata_o[1]), .uio_in(uio_in),
        .uio_out(uio_out_o[1]), .uio_oe(uio_oe_o[1]), .ale_hi(ale_hi_o[1]),
        .ale_lo(ale_lo_o[1]), .rd_n(rd_n_o[1]), .wr_n(wr_n_o[1])
    );

    typedef struct packed {
        logic       ready;
        logic       busy;
        logic [7:0] rdata;
        logic [7:0] uio_out;
        logic [7:0] uio_oe;
        logic       ale_hi;
        logic       ale_lo;
        logic       rd_n;
        logic       wr_n;
    } outs_t;

    typedef struct {
        logic        req;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  uio_in;
        outs_t       exp;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int ecount = 0;
    int wait_of[2] = '{1, 0};

    // Model: an access is described by its accept edge; outputs follow from the cycle offset.
    bit          m_act  [2];
    int          m_acc  [2];
    bit          m_we   [2];
    logic [15:0] m_addr [2];
    logic [7:0]  m_wdata[2];
    logic [7:0]  m_rdata[2];

    function automatic outs_t idle_outs(logic [7:0] rd);
        outs_t o;
        o = '0;
        o.rd_n  = 1'b1;
        o.wr_n  = 1'b1;
        o.rdata = rd;
        return o;
    endfunction

    function automatic outs_t model_out(int k);
        outs_t o;
        int pos;
        int w;
        w = wait_of[k];
        o = idle_outs(m_rdata[k]);
        if (!m_act[k]) return o;
        pos = ecount - m_acc[k] + 1;
        o.busy = 1'b1;
        if (pos == 1) begin
            o.ale_hi = 1'b1; o.uio_out = m_addr[k][15:8]; o.uio_oe = 8'hFF;
        end else if (pos == 2) begin
            o.ale_lo = 1'b1; o.uio_out = m_addr[k][7:0]; o.uio_oe = 8'hFF;
        end else begin
            if (pos > 3 + w) o.ready = 1'b1;
            if (m_we[k]) begin
                o.uio_out = m_wdata[k]; o.uio_oe = 8'hFF;
                if (pos <= 3 + w) o.wr_n = 1'b0;
            end else if (pos <= 3 + w) begin
                o.rd_n = 1'b0;
            end
        end
        return o;
    endfunction

    function automatic void model_edge(int k);
        bit was_idle;
        int p;
        int w;
        w = wait_of[k];
        if (rst) begin
            m_act[k]   = 1'b0;
            m_rdata[k] = 8'h00;
            return;
        end
        was_idle = !m_act[k];
        p = ecount - m_acc[k];
        if (m_act[k] && p == 3 + w && !m_we[k]) m_rdata[k] = uio_in;
        if (m_act[k] && p == 4 + w) m_act[k] = 1'b0;
        if (was_idle && req) begin
            m_act[k]   = 1'b1;
            m_acc[k]   = ecount;
            m_we[k]    = we;
            m_addr[k]  = addr;
            m_wdata[k] = wdata;
        end
    endfunction

    function automatic outs_t get_outs(int k);
        return '{ready_o[k], busy_o[k], rdata_o[k], uio_out_o[k], uio_oe_o[k],
                 ale_hi_o[k], ale_lo_o[k], rd_n_o[k], wr_n_o[k]};
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, got, exp, ecount);
        end
    endtask

    task automatic tick();
        outs_t e;
        @(posedge clk);
        ecount++;
        model_edge(0);
        model_edge(1);
        #1;
        for (int k = 0; k < 2; k++) begin
            e = model_out(k);
            chk($sformatf("model_dut%0d", k), 32'(get_outs(k)), 32'(e));
        end
    endtask

    task automatic drive(logic rq, logic w, logic [15:0] a, logic [7:0] wd, logic [7:0] ui);
        req = rq; we = w; addr = a; wdata = wd; uio_in = ui;
    endtask

    function automatic vec_t mk(logic rq, logic w, logic [15:0] a, logic [7:0] wd, logic [7:0] ui,
                                logic rdy, logic bsy, logic [7:0] rd, logic [7:0] uo, logic [7:0] oe,
                                logic ah, logic al, logic rn, logic wn);
        vec_t v;
        v.req = rq; v.we = w; v.addr = a; v.wdata = wd; v.uio_in = ui;
        v.exp = '{rdy, bsy, rd, uo, oe, ah, al, rn, wn};
        return v;
    endfunction

    vec_t tbl[18];
    int   cnt;
    int   pos_list[$];

    initial begin
        // WAIT_CYCLES=1 instance: write A55A/3C with mid-access req/addr noise, read 0102, write 1234.
        tbl[0]  = mk(1, 1, 16'hA55A, 8'h3C, 8'h00, 0, 1, 8'h00, 8'hA5, 8'hFF, 1, 0, 1, 1);
        tbl[1]  = mk(0, 0, 16'h0000, 8'h00, 8'h00, 0, 1, 8'h00, 8'h5A, 8'hFF, 0, 1, 1, 1);
        tbl[2]  = mk(1, 0, 16'hFFFF, 8'h11, 8'h00, 0, 1, 8'h00, 8'h3C, 8'hFF, 0, 0, 1, 0);
        tbl[3]  = mk(0, 1, 16'h1111, 8'h22, 8'h00, 0, 1, 8'h00, 8'h3C, 8'hFF, 0, 0, 1, 0);
        tbl[4]  = mk(1, 0, 16'h2222, 8'h33, 8'h00, 1, 1, 8'h00, 8'h3C, 8'hFF, 0, 0, 1, 1);
        tbl[5]  = mk(0, 0, 16'h0000, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1, 1);
        tbl[6]  = mk(1, 0, 16'h0102, 8'h00, 8'h00, 0, 1, 8'h00, 8'h01, 8'hFF, 1, 0, 1, 1);
        tbl[7]  = mk(0, 1, 16'hFFFF, 8'h00, 8'h00, 0, 1, 8'h00, 8'h02, 8'hFF, 0, 1, 1, 1);
        tbl[8]  = mk(0, 0, 16'h0000, 8'h00, 8'hC3, 0, 1, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1);
        tbl[9]  = mk(0, 0, 16'h0000, 8'h00, 8'hC3, 0, 1, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1);
        tbl[10] = mk(0, 0, 16'h0000, 8'h00, 8'hC3, 1, 1, 8'hC3, 8'h00, 8'h00, 0, 0, 1, 1);
        tbl[11] = mk(0, 0, 16'h0000, 8'h00, 8'h00, 0, 0, 8'hC3, 8'h00, 8'h00, 0, 0, 1, 1);
        tbl[12] = mk(1, 1, 16'h1234, 8'h77, 8'h00, 0, 1, 8'hC3, 8'h12, 8'hFF, 1, 0, 1, 1);
        tbl[13] = mk(0, 0, 16'h0000, 8'h00, 8'h00, 0, 1, 8'hC3, 8'h34, 8'hFF, 0, 1, 1, 1);
        tbl[14] = mk(0, 0, 16'h0000, 8'h00, 8'h00, 0, 1, 8'hC3, 8'h77, 8'hFF, 0, 0, 1, 0);
        tbl[15] = mk(0, 0, 16'h0000, 8'h00, 8'h00, 0, 1, 8'hC3, 8'h77, 8'hFF, 0, 0, 1, 0);
        tbl[16] = mk(0, 0, 16'h0000, 8'h00, 8'h00, 1, 1, 8'hC3, 8'h77, 8'hFF, 0, 0, 1, 1);
        tbl[17] = mk(0, 0, 16'h0000, 8'h00, 8'h00, 0, 0, 8'hC3, 8'h00, 8'h00, 0, 0, 1, 1);

        rst = 1'b1;
        drive(0, 0, 16'h0000, 8'h00, 8'h00);
        tick();
        tick();
        chk("reset_dut0", 32'(get_outs(0)), 32'(idle_outs(8'h00)));
        chk("reset_dut1", 32'(get_outs(1)), 32'(idle_outs(8'h00)));
        rst = 1'b0;
        tick();

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].req, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].uio_in);
            tick();
            chk($sformatf("vec%0d", i), 32'(get_outs(0)), 32'(tbl[i].exp));
        end

        // WAIT_CYCLES=0 read: rd_n low exactly one cycle, ready at offset 4 (offset 5 for WAIT=1).
        drive(1, 0, 16'hBEEF, 8'h00, 8'h5D);
        cnt = 0;
        for (int t = 1; t <= 8; t++) begin
            tick();
            req = 1'b0;
            if (!rd_n_o[1]) cnt++;
            if (ready_o[1]) chk("w0_ready_offset", 32'(t), 32'd4);
            if (ready_o[0]) chk("w1_ready_offset", 32'(t), 32'd5);
        end
        chk("w0_rd_low_cycles", 32'(cnt), 32'd1);
        chk("w0_rdata", 32'(rdata_o[1]), 32'h5D);

        // req held high: back-to-back writes accepted every 6 cycles on the WAIT=1 instance.
        drive(1, 1, 16'hC0DE, 8'hAB, 8'h00);
        pos_list.delete();
        for (int t = 1; t <= 18; t++) begin
            tick();
            if (ale_hi_o[0]) pos_list.push_back(t);
        end
        req = 1'b0;
        chk("held_req_accepts", 32'(pos_list.size()), 32'd3);
        if (pos_list.size() == 3) begin
            chk("held_req_acc0", 32'(pos_list[0]), 32'd1);
            chk("held_req_acc1", 32'(pos_list[1]), 32'd7);
            chk("held_req_acc2", 32'(pos_list[2]), 32'd13);
        end
        repeat (8) tick();

        // rst during the first DATA cycle of a write.
        drive(1, 1, 16'h4321, 8'h5A, 8'h00);
        tick();
        req = 1'b0;
        tick();
        tick();
        chk("pre_abort_wr_n", 32'(wr_n_o[0]), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_wr_n", 32'(wr_n_o[0]), 32'd1);
        chk("abort_uio_oe", 32'(uio_oe_o[0]), 32'h00);
        chk("abort_busy", 32'(busy_o[0]), 32'd0);
        cnt = 0;
        repeat (6) begin
            tick();
            if (ready_o[0]) cnt++;
        end
        chk("abort_no_ready", 32'(cnt), 32'd0);
        drive(1, 0, 16'h0F0F, 8'h00, 8'h9E);
        cnt = 0;
        for (int t = 1; t <= 10; t++) begin
            tick();
            req = 1'b0;
            if (ready_o[0] && cnt == 0) cnt = t;
        end
        chk("post_abort_ready_offset", 32'(cnt), 32'd5);
        chk("post_abort_rdata", 32'(rdata_o[0]), 32'h9E);

        // rst and req together: not accepted.
        rst = 1'b1;
        drive(1, 1, 16'h7777, 8'h77, 8'h00);
        tick();
        rst = 1'b0;
        req = 1'b0;
        chk("rst_req_busy", 32'(busy_o[0]), 32'd0);
        tick();
        chk("rst_req_no_start", 32'(ale_hi_o[0]), 32'd0);

        // Randomised traffic with occasional resets, checked against the model every cycle.
        for (int t = 0; t < 500; t++) begin
            rst = ($urandom_range(0, 99) == 0);
            drive(($urandom_range(0, 9) < 4), $urandom_range(0, 1),
                  16'($urandom), 8'($urandom), 8'($urandom));
            tick();
        end
        rst = 1'b0;
        req = 1'b0;
        repeat (8) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
